seg_display_arbiter: RTL and testbench

SEG_DISPLAY_ARBITER -- requirements
Module: seg_display_arbiter

---
 rtl/seg_display_arbiter.sv | 160 ++++++++++++++++
 tb/tb_seg_display_arbiter.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/seg_display_arbiter.sv
// Round-robin arbiter granting three requesters time on a two-digit multiplexed
// seven-segment display; each grant shows a latched hex byte for DWELL frames.
module seg_display_arbiter #(
    parameter int SCAN_DIV = 2500,
    parameter int DWELL    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] req,
    input  logic [7:0] val0,
    input  logic [7:0] val1,
    input  logic [7:0] val2,
    output logic [2:0] grant,
    output logic       done,
    output logic       busy,
    output logic [1:0] digit_sel,
    output logic [6:0] segment
);

    typedef enum logic [1:0] {IDLE, LOAD, SHOW} state_t;

    localparam logic [11:0] SCAN_LAST  = 12'(SCAN_DIV - 1);
    localparam logic [11:0] SCAN_PRE   = 12'(SCAN_DIV - 2);
    localparam logic [7:0]  FRAME_LAST = 8'(DWELL - 1);

    state_t      state_reg;
    logic [1:0]  last_reg;
    logic [1:0]  win_reg;
    logic [7:0]  latched_reg;
    logic [11:0] scan_reg;
    logic [7:0]  frame_reg;
    logic        low_reg;

    logic [1:0]  ord0, ord1, ord2;
    logic [1:0]  rr_idx;
    logic [7:0]  val_sel;

    function automatic logic [6:0] hex_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    // Search order starts just after the previous winner.
    always_comb begin
        ord0 = 2'd0;
        ord1 = 2'd1;
        ord2 = 2'd2;
        case (last_reg)
            2'd0: begin ord0 = 2'd1; ord1 = 2'd2; ord2 = 2'd0; end
            2'd1: begin ord0 = 2'd2; ord1 = 2'd0; ord2 = 2'd1; end
            default: begin ord0 = 2'd0; ord1 = 2'd1; ord2 = 2'd2; end
        endcase
        rr_idx = ord2;
        if (req[ord0])
            rr_idx = ord0;
        else if (req[ord1])
            rr_idx = ord1;
    end

    always_comb begin
        case (win_reg)
            2'd1:    val_sel = val1;
            2'd2:    val_sel = val2;
            default: val_sel = val0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            last_reg    <= 2'd2;
            win_reg     <= 2'd0;
            latched_reg <= 8'd0;
            scan_reg    <= 12'd0;
            frame_reg   <= 8'd0;
            low_reg     <= 1'b0;
            grant       <= 3'b000;
            done        <= 1'b0;
            busy        <= 1'b0;
            digit_sel   <= 2'b00;
            segment     <= 7'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    grant     <= 3'b000;
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    digit_sel <= 2'b00;
                    segment   <= 7'd0;
                    if (|req) begin
                        win_reg   <= rr_idx;
                        last_reg  <= rr_idx;
                        busy      <= 1'b1;
                        state_reg <= LOAD;
                    end
                end
                LOAD: begin
                    latched_reg <= val_sel;
                    grant       <= 3'b001 << win_reg;
                    busy        <= 1'b1;
                    done        <= 1'b0;
                    scan_reg    <= 12'd0;
                    frame_reg   <= 8'd0;
                    low_reg     <= 1'b0;
                    digit_sel   <= 2'b10;
                    segment     <= hex_decode(val_sel[7:4]);
                    state_reg   <= SHOW;
                end
                SHOW: begin
                    // done marks the cycle that will be the last of the final low phase.
                    done <= low_reg && (frame_reg == FRAME_LAST) && (scan_reg == SCAN_PRE);
                    if (scan_reg == SCAN_LAST) begin
                        scan_reg <= 12'd0;
                        if (!low_reg) begin
                            low_reg   <= 1'b1;
                            digit_sel <= 2'b01;
                            segment   <= hex_decode(latched_reg[3:0]);
                        end else if (frame_reg == FRAME_LAST) begin
                            state_reg <= IDLE;
                            frame_reg <= 8'd0;
                            low_reg   <= 1'b0;
                            grant     <= 3'b000;
                            busy      <= 1'b0;
                            done      <= 1'b0;
                            digit_sel <= 2'b00;
                            segment   <= 7'd0;
                        end else begin
                            frame_reg <= frame_reg + 8'd1;
                            low_reg   <= 1'b0;
                            digit_sel <= 2'b10;
                            segment   <= hex_decode(latched_reg[7:4]);
                        end
                    end else begin
                        scan_reg <= scan_reg + 12'd1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Directed plus randomized checks of seg_display_arbiter against a round-robin
// reference model that predicts winners and the expected scan pattern per grant.
module tb_seg_display_arbiter;

    localparam int SD       = 4;
    localparam int DW       = 2;
    localparam int SHOW_LEN = 2 * SD * DW;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] req = 3'b000;
    logic [7:0] val0 = 8'd0;
    logic [7:0] val1 = 8'd0;
    logic [7:0] val2 = 8'd0;
    logic [2:0] grant;
    logic       done;
    logic       busy;
    logic [1:0] digit_sel;
    logic [6:0] segment;

    int total  = 0;
    int passed = 0;
    int last_m = 2;

    logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    seg_display_arbiter #(.SCAN_DIV(SD), .DWELL(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .val0      (val0),
        .val1      (val1),
        .val2      (val2),
        .grant     (grant),
        .done      (done),
        .busy      (busy),
        .digit_sel (digit_sel),
        .segment   (segment)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout observed=running required=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_grant"}, 32'(grant), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_digit"}, 32'(digit_sel), 32'd0);
        chk({tag, "_seg"}, 32'(segment), 32'd0);
    endtask

    // Round-robin reference: scan from the index after the last winner.
    function automatic int model_winner(input logic [2:0] r);
        for (int k = 1; k <= 3; k++) begin
            int idx;
            idx = (last_m + k) % 3;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk_quiet("reset");
        rst = 1'b0;
        last_m = 2;
    endtask

    // Called at a negedge while the DUT is idle; returns at the negedge after the grant.
    task automatic run_grant(input logic [2:0] r, input logic [7:0] v0, input logic [7:0] v1,
                             input logic [7:0] v2, input int mut_k, input logic [2:0] r_after,
                             input int rst_k);
        int         w;
        logic [7:0] lv;
        logic [2:0] exp_g;
        logic [7:0] vals [3];
        logic [3:0] nib;
        bit         hi;
        req  = r;
        val0 = v0;
        val1 = v1;
        val2 = v2;
        vals = '{v0, v1, v2};
        w = model_winner(r);
        if (w < 0) begin
            repeat (3) begin
                @(negedge clk);
                chk_quiet("idle");
            end
            return;
        end
        lv     = vals[w];
        exp_g  = 3'b001 << w;
        last_m = w;
        @(negedge clk);
        chk("load_grant", 32'(grant), 32'd0);
        chk("load_busy", 32'(busy), 32'd1);
        @(negedge clk);
        for (int k = 0; k < SHOW_LEN; k++) begin
            hi  = ((k / SD) % 2) == 0;
            nib = hi ? lv[7:4] : lv[3:0];
            chk("show_grant", 32'(grant), 32'(exp_g));
            chk("show_digit", 32'(digit_sel), hi ? 32'd2 : 32'd1);
            chk("show_seg", 32'(segment), 32'(seg_tab[nib]));
            chk("show_done", 32'(done), (k == SHOW_LEN - 1) ? 32'd1 : 32'd0);
            chk("show_busy", 32'(busy), 32'd1);
            if (k == rst_k) begin
                rst = 1'b1;
                @(negedge clk);
                chk_quiet("midrst");
                rst = 1'b0;
                last_m = 2;
                return;
            end
            if (k == mut_k) begin
                val0 = 8'hFF;
                val1 = 8'hFF;
                val2 = 8'hFF;
                req  = r_after;
            end
            @(negedge clk);
        end
        chk_quiet("post");
        $display("grant=%b value=%02h checks=%0d", exp_g, lv, total);
    endtask

    initial begin
        int         mk;
        logic [2:0] r;
        logic [2:0] ra;
        @(negedge clk);
        do_reset();

        // Single request, then idle.
        run_grant(3'b001, 8'h3A, 8'h00, 8'h00, -1, 3'b000, -1);
        run_grant(3'b000, 8'h00, 8'h00, 8'h00, -1, 3'b000, -1);

        // Round-robin with all requests held.
        do_reset();
        run_grant(3'b111, 8'h01, 8'h23, 8'h45, -1, 3'b000, -1);
        run_grant(3'b111, 8'h01, 8'h23, 8'h45, -1, 3'b000, -1);
        run_grant(3'b111, 8'h01, 8'h23, 8'h45, -1, 3'b000, -1);
        run_grant(3'b111, 8'h01, 8'h23, 8'h45, -1, 3'b000, -1);

        // Value change mid-grant, then request drop mid-grant.
        run_grant(3'b010, 8'h00, 8'h12, 8'h00, 5, 3'b010, -1);
        run_grant(3'b100, 8'h00, 8'h00, 8'hC7, 5, 3'b000, -1);
        run_grant(3'b000, 8'h00, 8'h00, 8'h00, -1, 3'b000, -1);

        // Reset mid-SHOW, then requester 0 first.
        run_grant(3'b001, 8'hBE, 8'h00, 8'h00, -1, 3'b000, 7);
        run_grant(3'b011, 8'h9D, 8'h64, 8'h00, -1, 3'b000, -1);

        // Priority straight after reset.
        do_reset();
        run_grant(3'b110, 8'h00, 8'hE8, 8'h5F, -1, 3'b000, -1);

        // Randomized traffic.
        for (int t = 0; t < 30; t++) begin
            r  = 3'($urandom_range(0, 7));
            ra = 3'($urandom_range(0, 7));
            mk = int'($urandom_range(1, SHOW_LEN - 2));
            run_grant(r, 8'($urandom), 8'($urandom), 8'($urandom), mk, ra, -1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
